// File: rtl/neuron_ctrl.sv
// neuron_ctrl: leaky integrate-and-fire neuron controller.
//
// The membrane potential integrates unsigned input weights with saturation at
// 255. While integrating, a periodic leak subtracts leak_amt with a floor at
// 0. Once the registered potential reaches a nonzero threshold, the neuron
// fires a single-cycle spike. It then sits out a fixed refractory window
// before it integrates again.
//
// Ports
//   clk, reset       : rising-edge clock, synchronous active-high reset
//   enable           : run request; low parks the block in IDLE (count kept)
//   in_valid/in_ready: input spike handshake, accepted when both high
//   in_weight        : unsigned weight added on an accepted input
//   threshold        : firing threshold, 0 disables firing
//   leak_amt         : amount subtracted on each leak event
//   spike            : high for the one FIRE cycle
//   potential, timer : registered potential and leak/refractory counter
//   state            : IDLE=0, INTEGRATE=1, FIRE=2, REFRACT=3
//   spike_count      : total spikes fired, wraps modulo 256
module neuron_ctrl #(
  parameter int LEAK_PERIOD = 16,
  parameter int REFRACT     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       in_valid,
  input  logic [7:0] in_weight,
  output logic       in_ready,
  input  logic [7:0] threshold,
  input  logic [7:0] leak_amt,
  output logic       spike,
  output logic [7:0] potential,
  output logic [7:0] timer,
  output logic [1:0] state,
  output logic [7:0] spike_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_INTEG = 2'd1,
    S_FIRE  = 2'd2,
    S_REFR  = 2'd3
  } state_t;

  localparam logic [7:0] LEAK_LAST = 8'(LEAK_PERIOD - 1);
  localparam logic [7:0] REFR_LAST = 8'(REFRACT - 1);

  state_t     cur, nxt;
  logic [7:0] pot_n, tmr_n, cnt_n;
  logic       at_thresh, leak, accept;
  logic [7:0] after_leak;
  logic [8:0] summed;
  logic [7:0] pot_upd;

  // Compared against the live threshold input, so a new threshold is used on
  // the very next comparison.
  assign at_thresh = (threshold != 8'd0) && (potential >= threshold);
  assign leak      = (timer == LEAK_LAST);
  assign in_ready  = (cur == S_INTEG) && !at_thresh;
  assign accept    = in_valid && in_ready;
  assign spike     = (cur == S_FIRE);
  assign state     = cur;

  // Leak first (floored at 0), then add the weight in 9 bits and saturate.
  // Together these form one potential update.
  always_comb begin
    after_leak = potential;
    if (leak)
      after_leak = (potential > leak_amt) ? (potential - leak_amt) : 8'd0;
    summed  = {1'b0, after_leak} + {1'b0, (accept ? in_weight : 8'd0)};
    pot_upd = summed[8] ? 8'hFF : summed[7:0];
  end

  always_comb begin
    nxt   = cur;
    pot_n = potential;
    tmr_n = timer;
    cnt_n = spike_count;
    if (!enable) begin
      nxt   = S_IDLE;
      pot_n = 8'd0;
      tmr_n = 8'd0;
    end else begin
      case (cur)
        S_IDLE: begin
          nxt   = S_INTEG;
          pot_n = 8'd0;
          tmr_n = 8'd0;
        end
        S_INTEG: begin
          if (at_thresh) begin
            // Firing pre-empts both the leak and any input this cycle.
            nxt   = S_FIRE;
            tmr_n = 8'd0;
          end else begin
            pot_n = pot_upd;
            tmr_n = leak ? 8'd0 : timer + 8'd1;
          end
        end
        S_FIRE: begin
          nxt   = S_REFR;
          pot_n = 8'd0;
          tmr_n = 8'd0;
          cnt_n = spike_count + 8'd1;
        end
        S_REFR: begin
          pot_n = 8'd0;
          if (timer == REFR_LAST) begin
            nxt   = S_INTEG;
            tmr_n = 8'd0;
          end else begin
            tmr_n = timer + 8'd1;
          end
        end
        default: nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur         <= S_IDLE;
      potential   <= 8'd0;
      timer       <= 8'd0;
      spike_count <= 8'd0;
    end else begin
      cur         <= nxt;
      potential   <= pot_n;
      timer       <= tmr_n;
      spike_count <= cnt_n;
    end
  end

endmodule

// File: tb/tb_neuron_ctrl.sv
// Self-checking bench for neuron_ctrl: directed scenarios followed by a
// randomized run. A behavioural neuron model tracks the expected outputs.
module tb_neuron_ctrl;
  localparam int LP = 16;
  localparam int RF = 8;

  logic       clk = 1'b0;
  logic       reset, enable, in_valid;
  logic [7:0] in_weight, threshold, leak_amt;
  logic       in_ready, spike;
  logic [7:0] potential, timer, spike_count;
  logic [1:0] state;

  int checks = 0;
  int failures = 0;

  // model: phase 0 idle, 1 integrating, 2 firing, 3 refractory
  int m_phase = 0, m_pot = 0, m_since = 0, m_rc = 0, m_cnt = 0;

  neuron_ctrl #(.LEAK_PERIOD(LP), .REFRACT(RF)) dut (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
    .in_weight(in_weight), .in_ready(in_ready), .threshold(threshold),
    .leak_amt(leak_amt), .spike(spike), .potential(potential),
    .timer(timer), .state(state), .spike_count(spike_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int exp_timer();
    if (m_phase == 1) return m_since;
    if (m_phase == 3) return m_rc;
    return 0;
  endfunction

  function automatic bit exp_ready(input int th);
    return (m_phase == 1) && !(th != 0 && m_pot >= th);
  endfunction

  // One clock of neuron behaviour, given the inputs present at the edge.
  task automatic m_step(input bit r, input bit en, input bit v,
                        input int w, input int th, input int la);
    bit acc;
    acc = v && exp_ready(th);
    if (r) begin
      m_phase = 0; m_pot = 0; m_since = 0; m_rc = 0; m_cnt = 0;
    end else if (!en) begin
      m_phase = 0; m_pot = 0; m_since = 0; m_rc = 0;
    end else if (m_phase == 0) begin
      m_phase = 1; m_since = 0;
    end else if (m_phase == 1) begin
      if (th != 0 && m_pot >= th) begin
        m_phase = 2; m_since = 0;
      end else begin
        if (m_since == LP - 1) begin
          m_pot = (m_pot > la) ? m_pot - la : 0;
          m_since = 0;
        end else m_since++;
        if (acc) m_pot = (m_pot + w > 255) ? 255 : m_pot + w;
      end
    end else if (m_phase == 2) begin
      m_phase = 3; m_pot = 0; m_rc = 0; m_cnt = (m_cnt + 1) % 256;
    end else begin
      if (m_rc == RF - 1) begin
        m_phase = 1; m_since = 0; m_rc = 0;
      end else m_rc++;
    end
  endtask

  // Compare all registered outputs at the falling edge.
  task automatic obs();
    @(negedge clk);
    chk("state", int'(state), m_phase);
    chk("potential", int'(potential), m_pot);
    chk("timer", int'(timer), exp_timer());
    chk("spike_count", int'(spike_count), m_cnt);
    chk("spike", int'(spike), int'(m_phase == 2));
  endtask

  // Apply inputs for the next edge, check in_ready, then advance the model.
  task automatic drive(input bit r, input bit en, input bit v,
                       input int w, input int th, input int la);
    reset = r; enable = en; in_valid = v;
    in_weight = 8'(w); threshold = 8'(th); leak_amt = 8'(la);
    #1;
    chk("in_ready", int'(in_ready), int'(exp_ready(th)));
    m_step(r, en, v, w, th, la);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0);
    obs();
    drive(1, 0, 0, 0, 0, 0);
    obs();
  endtask

  initial begin
    int spikes, n;
    reset = 1; enable = 0; in_valid = 0; in_weight = 0;
    threshold = 0; leak_amt = 0;
    drive(1, 0, 0, 0, 0, 0);
    obs();
    chk("rst_ready", int'(in_ready), 0);

    // Steady weight 30 against threshold 100.
    do_reset();
    drive(0, 1, 1, 30, 100, 0);
    for (int k = 0; k < 15; k++) begin
      obs();
      if (k == 4) begin
        chk("r031_pot120", int'(potential), 120);
        chk("r031_ready0", int'(in_ready), 0);
      end
      if (k == 5) chk("r031_spike", int'(spike), 1);
      if (k == 13) chk("r031_refr_ready", int'(in_ready), 0);
      if (k == 14) chk("r031_ready_again", int'(in_ready), 1);
      drive(0, 1, 1, 30, 100, 0);
    end

    // A single weight of 50, decaying by 10 per leak.
    do_reset();
    drive(0, 1, 0, 0, 0, 10);
    for (int k = 0; k < 98; k++) begin
      obs();
      if (k > 0 && k % 16 == 0)
        chk("r032_leak", int'(potential), (50 - 10 * (k / 16) > 0) ? 50 - 10 * (k / 16) : 0);
      drive(0, 1, k == 0, 50, 0, 10);
    end

    // Threshold 0 with saturation.
    do_reset();
    drive(0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 12; k++) begin
      obs();
      if (k == 1) chk("r033_pot200", int'(potential), 200);
      if (k == 2) chk("r033_pot255", int'(potential), 255);
      drive(0, 1, k < 2, 200, 0, 0);
    end

    // Leak and accept in the same cycle.
    do_reset();
    drive(0, 1, 0, 0, 0, 10);
    for (int k = 0; k < 17; k++) begin
      obs();
      if (k == 16) chk("r034_pot", int'(potential), 20);
      drive(0, 1, (k == 0) || (k == 15), (k == 0) ? 5 : 20, 0, 10);
    end

    // Reset in the middle of the refractory window.
    do_reset();
    drive(0, 1, 1, 1, 1, 0);
    n = 0;
    obs();
    while (!(state == 2'd3 && timer == 8'd3) && n < 50) begin
      drive(0, 1, 1, 1, 1, 0);
      obs();
      n++;
    end
    chk("r035_reach", int'(timer), 3);
    drive(1, 1, 1, 1, 1, 0);
    obs();
    chk("r035_state", int'(state), 0);
    chk("r035_timer", int'(timer), 0);
    chk("r035_count", int'(spike_count), 0);
    drive(0, 1, 0, 0, 1, 0);
    obs();
    chk("r035_integ", int'(state), 1);

    // Wrap of spike_count, then drop enable mid-integration.
    do_reset();
    spikes = 0; n = 0;
    while (spikes < 257 && n < 6000) begin
      drive(0, 1, 1, 1, 1, 0);
      obs();
      if (spike) begin
        spikes++;
        if (spikes == 256) begin
          @(posedge clk); #1;
          chk("r036_wrap", int'(spike_count), 0);
        end
      end
      n++;
    end
    chk("r036_spikes", spikes, 257);
    n = 0;
    while (state != 2'd1 && n < 40) begin
      drive(0, 1, 0, 0, 5, 0);
      obs();
      n++;
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 1, 1, 5, 0);
      obs();
    end
    drive(0, 0, 1, 1, 5, 0);
    obs();
    chk("r036_idle", int'(state), 0);
    chk("r036_pot0", int'(potential), 0);
    chk("r036_cnt", int'(spike_count), 1);

    // Randomized traffic.
    begin
      int th, la;
      th = 60; la = 5;
      for (int k = 0; k < 4000; k++) begin
        if ($urandom_range(99) < 5)
          th = ($urandom_range(3) == 0) ? 0 : int'($urandom_range(255));
        if ($urandom_range(99) < 5) la = int'($urandom_range(40));
        drive($urandom_range(99) < 1, $urandom_range(99) >= 3,
              $urandom_range(99) < 70, int'($urandom_range(90)), th, la);
        obs();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
